// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the multiply/divide sequencer.
//   md_func_e  : EX_CTRL MDFunc encoding
//   md_state_e : sequencer states
//   MD_DIV0_LO : LO result for a divide by zero (slice to XLEN, XLEN <= 64)
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP  = 3'b000,
    MD_MULT = 3'b001,
    MD_DIV  = 3'b010,
    MD_MTHI = 3'b011,
    MD_MTLO = 3'b100,
    MD_MADD = 3'b101,
    MD_MSUB = 3'b110,
    MD_RSVD = 3'b111
  } md_func_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_e;

  localparam logic [63:0] MD_DIV0_LO = '1;

endpackage

// File: rtl/md_seq_ctrl_step.sv
// md_seq_ctrl_step (module md_step): one combinational algorithm step on the
// partial registers.
//   i_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_m   : multiplicand (MULT) or divisor (DIV), magnitude
//   i_a   : MULT upper product half / DIV partial remainder
//   i_q   : MULT multiplier + lower product / DIV dividend + quotient
//   o_a, o_q : registers after one step
module md_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_m,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_q,
  output logic [XLEN-1:0] o_a,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0]   w_sum;   // multiply: A + (q0 ? M : 0), carry kept
  logic [XLEN:0]   w_sh;    // divide: remainder shifted left with next dividend bit
  logic            w_borrow;
  logic [XLEN-1:0] w_diff;

  assign w_sum = {1'b0, i_a} + (i_q[0] ? {1'b0, i_m} : '0);
  assign w_sh  = {i_a, i_q[XLEN-1]};
  assign w_borrow = (w_sh < {1'b0, i_m});
  // Without a borrow the difference is below M, so XLEN bits hold it exactly.
  assign w_diff = w_sh[XLEN-1:0] - i_m;

  always_comb begin
    o_a = '0;
    o_q = '0;
    if (i_div) begin
      o_a = w_borrow ? w_sh[XLEN-1:0] : w_diff;
      o_q = {i_q[XLEN-2:0], ~w_borrow};
    end else begin
      // Product {A,Q} shifts right; the sum's low bit enters Q's top.
      o_a = w_sum[XLEN:1];
      o_q = {w_sum[0], i_q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: multi-cycle multiply/divide sequencer for EX. Owns HI/LO.
// Optional feature macro: MD_MADD_EN (enables MADD/MSUB; otherwise NOP).
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   md_start/md_func/md_sign/md_rs/md_rt : MD instruction in EX
//   md_read           : MFHI/MFLO in EX
//   md_flush          : EX flush, aborts any operation
//   md_busy           : operation in progress (CALC or FIX)
//   md_stall          : md_busy && (md_start || md_read)
//   md_hi, md_lo      : architectural HI/LO
//   md_done           : one-cycle pulse after MULT/DIV/MADD/MSUB writes HI/LO
module md_seq_ctrl
  import md_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_start,
  input  logic [2:0]      md_func,
  input  logic            md_sign,
  input  logic [XLEN-1:0] md_rs,
  input  logic [XLEN-1:0] md_rt,
  input  logic            md_read,
  input  logic            md_flush,
  output logic            md_busy,
  output logic            md_stall,
  output logic [XLEN-1:0] md_hi,
  output logic [XLEN-1:0] md_lo,
  output logic            md_done
);

  localparam int NSTEP = XLEN / STEPS_PER_CYCLE;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  md_state_e       r_state;
  md_func_e        r_func;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_m, r_a, r_q;
  logic            r_neg_q;   // quotient / product negative
  logic            r_neg_r;   // dividend negative -> remainder negative
  logic            r_div0;
  logic [XLEN-1:0] r_hi, r_lo;
  logic            r_done;

  md_func_e        w_func;
  logic            w_go_calc;
  logic            w_rs_neg, w_rt_neg;
  logic [XLEN-1:0] w_rs_abs, w_rt_abs;
  logic            w_is_div;

  assign w_func   = md_func_e'(md_func);
  assign w_rs_neg = md_sign & md_rs[XLEN-1];
  assign w_rt_neg = md_sign & md_rt[XLEN-1];
  assign w_rs_abs = w_rs_neg ? (~md_rs + 1'b1) : md_rs;
  assign w_rt_abs = w_rt_neg ? (~md_rt + 1'b1) : md_rt;
  assign w_is_div = (r_func == MD_DIV);

`ifdef MD_MADD_EN
  assign w_go_calc = (w_func == MD_MULT) || (w_func == MD_DIV) ||
                     (w_func == MD_MADD) || (w_func == MD_MSUB);
`else
  assign w_go_calc = (w_func == MD_MULT) || (w_func == MD_DIV);
`endif

  // Step chain: STEPS_PER_CYCLE steps per CALC cycle.
  logic [STEPS_PER_CYCLE:0][XLEN-1:0] w_a_ch, w_q_ch;
  assign w_a_ch[0] = r_a;
  assign w_q_ch[0] = r_q;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    md_step #(.XLEN(XLEN)) u_step (
      .i_div (w_is_div),
      .i_m   (r_m),
      .i_a   (w_a_ch[g]),
      .i_q   (w_q_ch[g]),
      .o_a   (w_a_ch[g+1]),
      .o_q   (w_q_ch[g+1])
    );
  end

  // FIX-stage result: sign correction and optional accumulate.
  logic [2*XLEN-1:0] w_prod, w_prod_s, w_res;
  logic [XLEN-1:0]   w_q_s, w_r_s;

  always_comb begin
    w_prod   = {r_a, r_q};
    w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    w_q_s    = r_neg_q ? (~r_q + 1'b1) : r_q;
    w_r_s    = r_neg_r ? (~r_a + 1'b1) : r_a;
    w_res    = w_prod_s;
    case (r_func)
      // Divide by zero: the remainder path already reproduces rs (|rs|
      // shifted through, sign restored), so only LO needs forcing.
      MD_DIV:  w_res = r_div0 ? {w_r_s, MD_DIV0_LO[XLEN-1:0]} : {w_r_s, w_q_s};
`ifdef MD_MADD_EN
      MD_MADD: w_res = {r_hi, r_lo} + w_prod_s;
      MD_MSUB: w_res = {r_hi, r_lo} - w_prod_s;
`endif
      default: w_res = w_prod_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_func  <= MD_NOP;
      r_cnt   <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (md_start && !md_flush) begin
            if (w_func == MD_MTHI) begin
              r_hi <= md_rs;
            end else if (w_func == MD_MTLO) begin
              r_lo <= md_rs;
            end else if (w_go_calc) begin
              r_state <= CALC;
              r_func  <= w_func;
              r_cnt   <= '0;
              r_a     <= '0;
              r_neg_q <= w_rs_neg ^ w_rt_neg;
              r_neg_r <= w_rs_neg;
              r_div0  <= (w_func == MD_DIV) && (md_rt == '0);
              if (w_func == MD_DIV) begin
                r_m <= w_rt_abs;
                r_q <= w_rs_abs;
              end else begin
                r_m <= w_rs_abs;
                r_q <= w_rt_abs;
              end
            end
          end
        end
        CALC: begin
          if (md_flush) begin
            r_state <= IDLE;
          end else begin
            r_a   <= w_a_ch[STEPS_PER_CYCLE];
            r_q   <= w_q_ch[STEPS_PER_CYCLE];
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          if (!md_flush) begin
            {r_hi, r_lo} <= w_res;
            r_done       <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign md_busy  = (r_state != IDLE);
  assign md_stall = md_busy && (md_start || md_read);
  assign md_hi    = r_hi;
  assign md_lo    = r_lo;
  assign md_done  = r_done;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb_md_seq_ctrl: table-driven vectors for MULT/DIV through a result
// scoreboard, plus hand sequences for stall, flush, reset, MT*, MADD.
module tb_md_seq_ctrl;

  localparam logic [2:0] F_NOP = 3'b000, F_MULT = 3'b001, F_DIV = 3'b010,
                         F_MTHI = 3'b011, F_MTLO = 3'b100, F_MADD = 3'b101;
  localparam int LAT = 34;  // cycle in which md_done appears

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        md_start = 1'b0, md_sign = 1'b0, md_read = 1'b0, md_flush = 1'b0;
  logic [2:0]  md_func = 3'b000;
  logic [31:0] md_rs = '0, md_rt = '0;
  logic        md_busy, md_stall, md_done;
  logic [31:0] md_hi, md_lo;

  int total = 0, bad = 0;
  logic [63:0] sb_q[$];

  md_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_func(md_func),
    .md_sign(md_sign), .md_rs(md_rs), .md_rt(md_rt), .md_read(md_read),
    .md_flush(md_flush), .md_busy(md_busy), .md_stall(md_stall),
    .md_hi(md_hi), .md_lo(md_lo), .md_done(md_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  func;
    logic        sign;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] exp;  // {HI, LO}
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] f, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    logic signed [31:0] sa, sb, sq, sr;
    sa = a; sb = b;
    if (f == F_MULT) begin
      ea = s ? {{32{a[31]}}, a} : {32'h0, a};
      eb = s ? {{32{b[31]}}, b} : {32'h0, b};
      return ea * eb;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Drive one calc op, track busy cycles, check latency and scoreboard result.
  task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input string tag);
    int cyc;
    int busy_cnt;
    bit got;
    logic [63:0] e;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    md_start = 1'b1; md_func = f; md_sign = s; md_rs = a; md_rt = b;
    @(posedge clk); #1;
    md_start = 1'b0; md_func = F_NOP;
    cyc = 1; busy_cnt = 0; got = 0;
    while (!got && cyc <= 60) begin
      @(negedge clk);
      if (md_done) got = 1;
      else begin
        if (md_busy) busy_cnt++;
        cyc++;
      end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 64'(got), 64'd1);
      void'(sb_q.pop_front());
    end else begin
      chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
      chk({tag, "_busycyc"}, 64'(busy_cnt), 64'(LAT - 1));
      chk({tag, "_busy_at_done"}, 64'(md_busy), 64'd0);
      e = sb_q.pop_front();
      chk({tag, "_hilo"}, {md_hi, md_lo}, e);
    end
  endtask

  // MTHI/MTLO: written at the accepting edge, never busy.
  task automatic mt(input logic [2:0] f, input logic [31:0] v, input string tag);
    logic b0;
    @(posedge clk); #1;
    md_start = 1'b1; md_func = f; md_rs = v;
    @(negedge clk); b0 = md_busy;
    @(posedge clk); #1;
    md_start = 1'b0; md_func = F_NOP;
    @(negedge clk);
    chk({tag, "_val"}, (f == F_MTHI) ? 64'(md_hi) : 64'(md_lo), 64'(v));
    chk({tag, "_busy"}, 64'({b0, md_busy, md_done}), 64'd0);
  endtask

  initial begin
    logic [63:0] e;
    int cyc;
    bit got, ok;

    vt[0] = '{F_MULT, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, {32'h0000_0001, 32'hFFFF_FFFE}};
    vt[1] = '{F_DIV,  1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vt[2] = '{F_DIV,  1'b0, 32'h0000_0005, 32'h0000_0000, {32'h0000_0005, 32'hFFFF_FFFF}};
    vt[3] = '{F_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}};
    vt[4] = '{F_MULT, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, {32'hFFFF_FFFF, 32'hFFFF_FFF1}};
    vt[5] = '{F_DIV,  1'b0, 32'h0000_0064, 32'h0000_0007, {32'h0000_0002, 32'h0000_000E}};
    vt[6] = '{F_DIV,  1'b1, 32'hFFFF_FFFB, 32'h0000_0000, {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
    vt[7] = '{F_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}};
    for (int i = 8; i < 14; i++) begin
      vt[i].func = (i % 2 == 0) ? F_MULT : F_DIV;
      vt[i].sign = 1'($urandom_range(0, 1));
      vt[i].rs   = $urandom;
      vt[i].rt   = (i == 11) ? 32'($urandom_range(1, 300)) : $urandom;
      vt[i].exp  = model(vt[i].func, vt[i].sign, vt[i].rs, vt[i].rt);
    end

    // Reset state
    #3;
    chk("reset_state", {md_hi, md_lo, 30'h0, md_busy, md_done}, 96'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(vt[i].func, vt[i].sign, vt[i].rs, vt[i].rt, vt[i].exp, $sformatf("vec%0d", i));

    // Stall: MULT, then MFHI and a second MULT held in EX while busy.
    sb_q.push_back(model(F_MULT, 1'b0, 32'h0000_1234, 32'h0000_0010));
    sb_q.push_back(model(F_MULT, 1'b1, 32'h8000_0001, 32'h0000_0003));
    @(posedge clk); #1;
    md_start = 1'b1; md_func = F_MULT; md_sign = 1'b0; md_rs = 32'h1234; md_rt = 32'h10;
    @(posedge clk); #1;
    md_read = 1'b1; md_sign = 1'b1; md_rs = 32'h8000_0001; md_rt = 32'h3;
    ok = 1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (!md_stall || md_done) ok = 0;
    end
    chk("stall_hold", 64'(ok), 64'd1);
    @(negedge clk);
    chk("stall_release", {md_stall, md_done}, 2'b01);
    e = sb_q.pop_front();
    chk("stall_first_hilo", {md_hi, md_lo}, e);
    @(posedge clk); #1;
    md_start = 1'b0; md_read = 1'b0; md_func = F_NOP;
    @(negedge clk);
    chk("held_accepted", 64'(md_busy), 64'd1);
    cyc = 35; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk); cyc++;
      if (md_done) got = 1;
    end
    chk("held_lat", 64'(cyc), 64'(2 * LAT));
    e = sb_q.pop_front();
    chk("held_hilo", {md_hi, md_lo}, e);

    // Flush during DIV
    mt(F_MTHI, 32'h11, "mthi");
    mt(F_MTLO, 32'h22, "mtlo");
    @(posedge clk); #1;
    md_start = 1'b1; md_func = F_DIV; md_sign = 1'b0; md_rs = 32'd100; md_rt = 32'd3;
    @(posedge clk); #1;
    md_start = 1'b0; md_func = F_NOP;
    for (int c = 2; c <= 10; c++) begin @(posedge clk); #1; end
    md_flush = 1'b1;
    @(posedge clk); #1;
    md_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {md_busy, md_hi, md_lo}, {1'b0, 32'h11, 32'h22});
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_done) got = 1;
    end
    chk("flush_no_done", 64'(got), 64'd0);
    chk("flush_hilo", {md_hi, md_lo}, {32'h11, 32'h22});

    // Flush with MTHI start: flush wins
    @(posedge clk); #1;
    md_start = 1'b1; md_func = F_MTHI; md_rs = 32'hDEAD_BEEF; md_flush = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; md_func = F_NOP; md_flush = 1'b0;
    @(negedge clk);
    chk("flush_mthi", {md_busy, md_hi}, {1'b0, 32'h11});

    // Asynchronous reset mid-MULT
    @(posedge clk); #1;
    md_start = 1'b1; md_func = F_MULT; md_rs = 32'h7; md_rt = 32'h9;
    @(posedge clk); #1;
    md_start = 1'b0; md_func = F_NOP;
    for (int c = 2; c <= 20; c++) begin @(posedge clk); #1; end
    chk("pre_reset_busy", 64'(md_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {md_hi, md_lo, md_busy, md_done}, 66'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mt(F_MTLO, 32'hA5A5_A5A5, "mtlo_after_rst");

`ifdef MD_MADD_EN
    mt(F_MTHI, 32'h0, "madd_sethi");
    mt(F_MTLO, 32'hFFFF_FFFF, "madd_setlo");
    run_op(F_MADD, 1'b0, 32'h1, 32'h1, {32'h1, 32'h0}, "madd");
`else
    mt(F_MTHI, 32'h0, "madd_sethi");
    mt(F_MTLO, 32'hFFFF_FFFF, "madd_setlo");
    @(posedge clk); #1;
    md_start = 1'b1; md_func = F_MADD; md_sign = 1'b0; md_rs = 32'h1; md_rt = 32'h1;
    @(posedge clk); #1;
    md_start = 1'b0; md_func = F_NOP;
    ok = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (md_busy || md_done) ok = 0;
    end
    chk("madd_off_idle", 64'(ok), 64'd1);
    chk("madd_off_hilo", {md_hi, md_lo}, {32'h0, 32'hFFFF_FFFF});
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
